idct_mac_accum: RTL and testbench
=================================

# idct_mac_accum

Downstream consumer of the approximate IDCT multiplier wrapper. Takes the wrapper's 32-bit signed product stream `P` and accumulates TAPS consecutive products into one IDCT output sample. Rounds, shifts and optionally saturates each sum, then presents it on a valid/ready output port. Counts samples within an 8x8 block and flags the last one.

## Interface
Parameters:
- `TAPS`, 8: products summed per output sample.
- `ACC_WIDTH`, 40: signed accumulator width.
- `OUT_WIDTH`, 16: signed output sample width.
- `ROW_SHIFT`, 8: right-shift applied on the row pass (`pass`=0).
- `COL_SHIFT`, 11: right-shift applied on the column pass (`pass`=1).

Ports:
- `clk`  in  1: single clock, rising edge.
- `racc`  in  1: **asynchronous, active-high** reset of all state.
- `flush`  in  1: synchronous; discard any partial accumulation.
- `pass`  in  1: 0 = row pass, 1 = column pass; sampled on the first tap of each sample.
- `prod`  in  32: signed product (the multiplier wrapper's `P`).
- `prod_valid`  in  1: `prod` is valid.
- `prod_ready`  out  1: block accepts `prod` this cycle.
- `out_data`  out  OUT_WIDTH: signed result sample.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer takes `out_data`.
- `out_idx`  out  6: index 0..63 of the sample on `out_data` within the block.
- `block_done`  out  1: one-cycle pulse on the transfer of index 63.

## Operation
- FSM has two states.
  - `ACCUM`: `prod_ready`=1.
  - `ROUND`: `prod_ready`=0.
  - Reset state is `ACCUM`.
- A product transfers on `prod_valid && prod_ready`.
  - On tap 0: `acc` = sign-extended `prod`, and `pass` is latched into `pass_q`.
  - On later taps: `acc` += `prod`.
  - The `tap_cnt` counter (0..TAPS-1) increments on each transfer.
- When tap TAPS-1 transfers, the FSM moves to `ROUND` and `tap_cnt` wraps to 0.
- Rounding in `ROUND`: `r = (acc + (1 << (S-1))) >>> S`.
  - S = ROW_SHIFT when `pass_q`=0, COL_SHIFT when `pass_q`=1.
  - The shift is arithmetic (floor).
- Leaving `ROUND`:
  - If the output register is empty, or is being drained this cycle (`out_valid && out_ready`), then `out_data` = `r` narrowed to OUT_WIDTH, `out_valid` is set, and the FSM returns to `ACCUM`.
  - Otherwise the FSM stays in `ROUND` (stall).
- `out_idx` increments on each output transfer and wraps 63→0.
- `block_done` = `out_valid && out_ready && out_idx == 63`.
- `flush`:
  - Clears `acc` and `tap_cnt`, and forces the FSM to `ACCUM`.
  - Does not affect the output register or `out_idx`.
  - If `flush` and a product transfer occur in the same cycle, `flush` wins and the product is dropped.
- Reset values: `acc`=0, `tap_cnt`=0, `pass_q`=0, `out_data`=0, `out_valid`=0, `out_idx`=0, `block_done`=0, `prod_ready`=1 (FSM in `ACCUM`).
- Reset mid-accumulation or mid-stall: all partial state is lost, with no output.

## Timing
- Latency: the last tap transfers at edge N; `out_valid` rises after edge N+1 if the output register is free.
- There is one bubble cycle (`prod_ready`=0) per sample, so peak throughput is one sample per TAPS+1 cycles.
- `out_data` and `out_valid` are registered and stay stable while `out_valid && !out_ready`.
- `prod_ready` is a function of the FSM state only, with no combinational path from `out_ready`.

## Configuration
- Macro: `IDCT_ACC_SAT_EN`.
- Defined: `r` is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Undefined: `r` is truncated to its low OUT_WIDTH bits (wrap-around).

## Structure
- Shared package `idct_pkg` holds:
  - FSM state typedef (`ACCUM`, `ROUND`);
  - default constants TAPS, ROW_SHIFT, COL_SHIFT, ACC_WIDTH, OUT_WIDTH;
  - block size 64.
- One sub-module, `idct_round_sat`: combinational round/shift/narrow (saturate under `IDCT_ACC_SAT_EN`), parameterised by ACC_WIDTH and OUT_WIDTH, with S as an input.

## Test plan
All scenarios use default parameters.
1. Eight products of 256, `pass`=0, `out_ready`=1 → `out_data`=8 ((2048+128)>>>8), `out_valid` two edges after the last tap, `out_idx`=0.
2. Eight products of -384, `pass`=0 → `out_data`=-12 (floor of -2944/256).
3. Eight products of 0x7FFF0000, `pass`=0:
   - with `IDCT_ACC_SAT_EN` → `out_data`=32767;
   - without → `out_data`=0xF800 (-2048).
4. Backpressure: hold `out_ready`=0 and complete two samples → `prod_ready` stays 0 in the second `ROUND`. Raise `out_ready` → first sample transfers, second loads on that edge, and `prod_ready` returns to 1 the next cycle.
5. `flush` after tap 3, then eight products of 2048 with `pass`=1 → `out_data`=8 ((16384+1024)>>>11); the partial sum is discarded.
6. Stream 64 samples, then assert `racc` mid-way through sample 65 → `block_done` pulses exactly on the transfer of index 63, `out_idx` wraps to 0, and after reset `out_valid`=0, `prod_ready`=1, `out_idx`=0.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared types and default constants for the IDCT accumulate/round stage.
package idct_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    ROUND = 1'b1
  } state_t;

  localparam int IDCT_TAPS       = 8;
  localparam int IDCT_ROW_SHIFT  = 8;
  localparam int IDCT_COL_SHIFT  = 11;
  localparam int IDCT_ACC_WIDTH  = 40;
  localparam int IDCT_OUT_WIDTH  = 16;
  localparam int IDCT_BLOCK_SIZE = 64;
  localparam int IDCT_IDX_WIDTH  = $clog2(IDCT_BLOCK_SIZE);

endpackage

// File: rtl/idct_round_sat.sv
// Combinational round-half-up, arithmetic right shift and narrowing of an accumulator.
// IDCT_ACC_SAT_EN selects clamping to the output range instead of wrap-around.
module idct_round_sat
  import idct_pkg::*;
#(
  parameter int ACC_WIDTH = IDCT_ACC_WIDTH,
  parameter int OUT_WIDTH = IDCT_OUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic        [5:0]           shift,
  output logic signed [OUT_WIDTH-1:0] res
);

  // One guard bit so adding the rounding bias can never overflow.
  localparam int SW = ACC_WIDTH + 1;

`ifdef IDCT_ACC_SAT_EN
  localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = ~MAX_V;
`endif

  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] bias;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;

  always_comb begin
    ext  = {acc[ACC_WIDTH-1], acc};
    bias = '0;
    if (shift != 6'd0) begin
      bias = SW'(1) << (shift - 6'd1);
    end
    sum     = ext + bias;
    shifted = sum >>> shift;
`ifdef IDCT_ACC_SAT_EN
    if (shifted > MAX_V) begin
      res = MAX_V[OUT_WIDTH-1:0];
    end else if (shifted < MIN_V) begin
      res = MIN_V[OUT_WIDTH-1:0];
    end else begin
      res = shifted[OUT_WIDTH-1:0];
    end
`else
    res = shifted[OUT_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/idct_mac_accum.sv
// Sums TAPS signed products per IDCT sample, rounds/shifts per pass and emits on valid/ready.
// Build option IDCT_ACC_SAT_EN clamps results instead of wrapping (see idct_round_sat).
module idct_mac_accum
  import idct_pkg::*;
#(
  parameter int TAPS      = IDCT_TAPS,
  parameter int ACC_WIDTH = IDCT_ACC_WIDTH,
  parameter int OUT_WIDTH = IDCT_OUT_WIDTH,
  parameter int ROW_SHIFT = IDCT_ROW_SHIFT,
  parameter int COL_SHIFT = IDCT_COL_SHIFT
) (
  input  logic                        clk,
  input  logic                        racc,
  input  logic                        flush,
  input  logic                        pass,
  input  logic        [31:0]          prod,
  input  logic                        prod_valid,
  output logic                        prod_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDCT_IDX_WIDTH-1:0]   out_idx,
  output logic                        block_done
);

  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_t                        state;
  logic   [CW-1:0]               tap_cnt;
  logic   signed [ACC_WIDTH-1:0] acc;
  logic                          pass_q;
  logic   signed [ACC_WIDTH-1:0] prod_ext;
  logic   signed [OUT_WIDTH-1:0] rounded;
  logic   [5:0]                  shift;
  logic                          take;
  logic                          drain;
  logic                          load;
  logic                          last_tap;

  always_comb begin
    prod_ext = {{(ACC_WIDTH-32){prod[31]}}, prod};
    take     = prod_valid && prod_ready && !flush;
    drain    = out_valid && out_ready;
    load     = (state == ROUND) && !flush && (!out_valid || out_ready);
    last_tap = (tap_cnt == CW'(TAPS - 1));
    shift    = pass_q ? 6'(COL_SHIFT) : 6'(ROW_SHIFT);
  end

  assign block_done = drain && (out_idx == IDCT_IDX_WIDTH'(IDCT_BLOCK_SIZE - 1));

  idct_round_sat #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_round (
    .acc  (acc),
    .shift(shift),
    .res  (rounded)
  );

  // prod_ready is kept as a register mirroring the state so out_ready never reaches it.
  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      state      <= ACCUM;
      prod_ready <= 1'b1;
      acc        <= '0;
      tap_cnt    <= '0;
      pass_q     <= 1'b0;
    end else if (flush) begin
      state      <= ACCUM;
      prod_ready <= 1'b1;
      acc        <= '0;
      tap_cnt    <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (take) begin
            if (tap_cnt == '0) begin
              acc    <= prod_ext;
              pass_q <= pass;
            end else begin
              acc <= acc + prod_ext;
            end
            if (last_tap) begin
              tap_cnt    <= '0;
              state      <= ROUND;
              prod_ready <= 1'b0;
            end else begin
              tap_cnt <= tap_cnt + CW'(1);
            end
          end
        end
        ROUND: begin
          if (load) begin
            state      <= ACCUM;
            prod_ready <= 1'b1;
          end
        end
        default: begin
          state      <= ACCUM;
          prod_ready <= 1'b1;
        end
      endcase
    end
  end

  // Output register: a fresh sample may load on the same edge the previous one drains.
  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      if (load) begin
        out_data  <= rounded;
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drain) begin
        out_idx <= out_idx + IDCT_IDX_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_idct_mac_accum.sv
// Self-checking bench for idct_mac_accum: directed scenarios plus a random 64-sample stream.
// Expected samples come from a floor-division model of the round/shift/narrow rule.
module tb_idct_mac_accum;

  logic        clk = 1'b0;
  logic        racc;
  logic        flush;
  logic        pass;
  logic [31:0] prod;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_idx;
  logic        block_done;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [15:0] exp_q[$];
  int          model_idx  = 0;
  int          model_taps = 0;
  longint      model_sum  = 0;
  bit          model_pass = 1'b0;
  int          done_seen  = 0;
  bit          held       = 1'b0;
  logic [15:0] held_data;

  always #5 clk = ~clk;

  idct_mac_accum dut (
    .clk       (clk),
    .racc      (racc),
    .flush     (flush),
    .pass      (pass),
    .prod      (prod),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .block_done(block_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Round half up then floor-divide by 2^S, then narrow to 16 bits.
  function automatic logic [15:0] model_round(input longint sum, input bit ps);
    longint div;
    longint num;
    longint q;
    div = ps ? 64'sd2048 : 64'sd256;
    num = sum + div / 2;
    q   = num / div;
    if ((num % div != 0) && (num < 0)) q = q - 1;
`ifdef IDCT_ACC_SAT_EN
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
`endif
    return q[15:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input bit ps);
    int waited = 0;
    prod       = p;
    pass       = ps;
    prod_valid = 1'b1;
    @(negedge clk);
    while (!prod_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("prod_ready_wait", 64'(waited < 200), 64'd1);
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    if (model_taps == 0) begin
      model_sum  = longint'($signed(p));
      model_pass = ps;
    end else begin
      model_sum += longint'($signed(p));
    end
    model_taps++;
    if (model_taps == 8) begin
      exp_q.push_back(model_round(model_sum, model_pass));
      model_taps = 0;
    end
  endtask

  task automatic send8(input logic [31:0] v, input bit ps);
    for (int i = 0; i < 8; i++) push(v, ps);
  endtask

  // Output-side monitor: every transfer is matched against the model's queue and index.
  always @(negedge clk) begin
    logic [15:0] expv;
    if (racc) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(held_data));
      end
      if (out_valid && out_ready) begin
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        check("out_data", 64'(out_data), 64'(expv));
        check("out_idx", 64'(out_idx), 64'(model_idx[5:0]));
        check("block_done", 64'(block_done), 64'(model_idx == 63));
        if (block_done) done_seen++;
        model_idx = (model_idx + 1) % 64;
      end else begin
        check("block_done_idle", 64'(block_done), 64'd0);
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  initial begin
    logic [15:0] exp_b;
    racc       = 1'b1;
    flush      = 1'b0;
    pass       = 1'b0;
    prod       = '0;
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    tick(2);
    check("rst_prod_ready", 64'(prod_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_block_done", 64'(block_done), 64'd0);
    racc = 1'b0;
    tick(1);

    // Scenario 1: basic row-pass sum and output latency.
    send8(32'd256, 1'b0);
    check("s1_valid_early", 64'(out_valid), 64'd0);
    check("s1_bubble", 64'(prod_ready), 64'd0);
    tick(1);
    check("s1_valid", 64'(out_valid), 64'd1);
    check("s1_data", 64'(out_data), 64'd8);
    check("s1_idx", 64'(out_idx), 64'd0);
    check("s1_ready_back", 64'(prod_ready), 64'd1);
    tick(1);
    check("s1_drained", 64'(out_valid), 64'd0);

    // Scenario 2: negative sum floors toward minus infinity.
    send8(-32'sd384, 1'b0);
    tick(1);
    check("s2_data", 64'(out_data), 64'(16'hFFF4));
    tick(1);

    // Scenario 3: large sum, wrap or clamp depending on build.
    send8(32'h7FFF0000, 1'b0);
    tick(1);
`ifdef IDCT_ACC_SAT_EN
    check("s3_data", 64'(out_data), 64'(16'h7FFF));
`else
    check("s3_data", 64'(out_data), 64'(16'hF800));
`endif
    tick(1);

    // Scenario 4: backpressure across two samples.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push($urandom, 1'b0);
    for (int i = 0; i < 8; i++) push($urandom, 1'b1);
    check("s4_stall_a", 64'(prod_ready), 64'd0);
    tick(3);
    check("s4_stall_b", 64'(prod_ready), 64'd0);
    check("s4_valid_held", 64'(out_valid), 64'd1);
    exp_b     = exp_q[1];
    out_ready = 1'b1;
    tick(1);
    check("s4_b_valid", 64'(out_valid), 64'd1);
    check("s4_b_data", 64'(out_data), 64'(exp_b));
    check("s4_ready_back", 64'(prod_ready), 64'd1);
    tick(2);

    // Scenario 5: flush after four taps, with a simultaneous product that must be dropped.
    for (int i = 0; i < 4; i++) push($urandom, 1'b0);
    flush      = 1'b1;
    prod_valid = 1'b1;
    prod       = $urandom;
    tick(1);
    flush      = 1'b0;
    prod_valid = 1'b0;
    model_taps = 0;
    send8(32'd2048, 1'b1);
    tick(1);
    check("s5_data", 64'(out_data), 64'd8);
    tick(2);

    // Scenario 6: random stream across the block boundary, then reset mid-sample.
    for (int s = 0; s < 64; s++) begin
      for (int t = 0; t < 8; t++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        push($urandom, 1'($urandom_range(0, 1)));
      end
    end
    out_ready = 1'b1;
    tick(4);
    check("s6_done_count", 64'(done_seen), 64'd1);
    check("s6_queue_empty", 64'(exp_q.size()), 64'd0);
    check("s6_idx_wrapped", 64'(out_idx), 64'(model_idx[5:0]));

    for (int i = 0; i < 3; i++) push($urandom, 1'b0);
    racc = 1'b1;
    tick(1);
    check("s6_rst_valid", 64'(out_valid), 64'd0);
    check("s6_rst_ready", 64'(prod_ready), 64'd1);
    check("s6_rst_idx", 64'(out_idx), 64'd0);
    racc       = 1'b0;
    model_taps = 0;
    model_idx  = 0;
    exp_q.delete();
    tick(1);
    send8(32'd256, 1'b0);
    tick(1);
    check("s6_post_data", 64'(out_data), 64'd8);
    check("s6_post_idx", 64'(out_idx), 64'd0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
